// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Optional feature macro: PC_TRAP_EN (adds the TRAP state for misaligned redirects).
package pc_seq_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;

`ifdef PC_TRAP_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
`endif

  // Source of the next PC value
  typedef enum logic [2:0] {
    SEL_RESET  = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_INC    = 3'd2,
    SEL_TARGET = 3'd3,
    SEL_TRAP   = 3'd4
  } pc_sel_t;

  // Force an address onto an instruction-word boundary
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector feeding the PC register D input.
// Optional feature macro: PC_TRAP_EN (SEL_TRAP is only selected when it is defined).
import pc_seq_pkg::*;

module pc_next_mux #(
  parameter logic [PC_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_ADDR  = 32'h0000_0080
) (
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] pc_q,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_d
);

  // Pick the next PC; increment wraps modulo 2^32
  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_RESET:  pc_d = RESET_ADDR;
      SEL_INC:    pc_d = pc_q + PC_W'(INSTR_BYTES);
      SEL_TARGET: pc_d = align_word(target);
      SEL_TRAP:   pc_d = TRAP_ADDR;
      default:    pc_d = pc_q;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: drives the PC register, handshakes imem, hands words to decode,
// applies branch/jump redirects from execute.
// Optional feature macro: PC_TRAP_EN (misaligned redirect traps to TRAP_ADDR; adds trap ports).
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter logic [PC_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_ADDR  = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_q,
  output logic [PC_W-1:0] pc_d,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target
`ifdef PC_TRAP_EN
  ,
  output logic            trap_valid,
  output logic [PC_W-1:0] trap_epc
`endif
);

  state_t  state;
  logic    instr_hold;
  logic    redirect_ok;
  pc_sel_t sel;

  // Redirects only count once fetching has started (ignored in BOOT)
  assign redirect_ok = redirect_valid & ((state == ST_FETCH) | (state == ST_HOLD));

`ifdef PC_TRAP_EN
  logic take_trap;
  assign take_trap = redirect_ok & (redirect_target[1:0] != 2'b00);
`endif

  assign imem_addr   = pc_q;
  // A redirect squashes the held word in the same cycle, so no transfer can happen
  assign instr_valid = instr_hold & ~redirect_valid;

  // Next-PC source; redirect outranks ack and ready
  always_comb begin
    sel = SEL_HOLD;
    if (state == ST_BOOT) begin
      sel = SEL_RESET;
    end
`ifdef PC_TRAP_EN
    else if (state == ST_TRAP) begin
      sel = SEL_TRAP;
    end else if (take_trap) begin
      sel = SEL_HOLD;
    end
`endif
    else if (redirect_ok) begin
      sel = SEL_TARGET;
    end else if ((state == ST_FETCH) && imem_ack) begin
      sel = SEL_INC;
    end
  end

  pc_next_mux #(
    .RESET_ADDR (RESET_ADDR),
    .TRAP_ADDR  (TRAP_ADDR)
  ) u_pc_next_mux (
    .sel    (sel),
    .pc_q   (pc_q),
    .target (redirect_target),
    .pc_d   (pc_d)
  );

  // Fetch FSM with registered request/holding outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      imem_req   <= 1'b0;
      instr_hold <= 1'b0;
      instr      <= '0;
      instr_pc   <= '0;
`ifdef PC_TRAP_EN
      trap_valid <= 1'b0;
      trap_epc   <= '0;
`endif
    end else begin
`ifdef PC_TRAP_EN
      trap_valid <= 1'b0;
`endif
      case (state)
        ST_BOOT: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH, ST_HOLD: begin
`ifdef PC_TRAP_EN
          if (take_trap) begin
            state      <= ST_TRAP;
            imem_req   <= 1'b0;
            instr_hold <= 1'b0;
            trap_valid <= 1'b1;
            trap_epc   <= redirect_target;
          end else
`endif
          if (redirect_valid) begin
            state      <= ST_FETCH;
            imem_req   <= 1'b1;
            instr_hold <= 1'b0;
          end else if ((state == ST_FETCH) && imem_ack) begin
            state      <= ST_HOLD;
            imem_req   <= 1'b0;
            instr_hold <= 1'b1;
            instr      <= imem_rdata;
            instr_pc   <= pc_q;
          end else if ((state == ST_HOLD) && instr_ready) begin
            state      <= ST_FETCH;
            imem_req   <= 1'b1;
            instr_hold <= 1'b0;
          end
        end
`ifdef PC_TRAP_EN
        ST_TRAP: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
`endif
        default: begin
          state      <= ST_BOOT;
          imem_req   <= 1'b0;
          instr_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with an external PC register and a
// transaction-level reference model (boot / fetch outstanding / word held).
// Optional feature macro: PC_TRAP_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_ADDR = 32'h0040_0000;
  localparam logic [31:0] TRAP_ADDR  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q = '0;
  logic [31:0] pc_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
`ifdef PC_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_epc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_boot, m_fetch, m_held;
  logic [31:0] m_pc, m_instr, m_instr_pc;
  logic [31:0] exp_pcd;
  logic        exp_req, exp_valid;

  always #5 clk = ~clk;

  // External PC register (no enable)
  always @(posedge clk) pc_q <= pc_d;

  pc_sequencer #(
    .RESET_ADDR (RESET_ADDR),
    .TRAP_ADDR  (TRAP_ADDR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_q            (pc_q),
    .pc_d            (pc_d),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
`ifdef PC_TRAP_EN
    ,
    .trap_valid      (trap_valid),
    .trap_epc        (trap_epc)
`endif
  );

  // Apply inputs, let combinational logic settle, derive expectations from the model
  task automatic drive(input logic a, input logic [31:0] rd, input logic r,
                       input logic rv, input logic [31:0] t);
    imem_ack = a; imem_rdata = rd; instr_ready = r;
    redirect_valid = rv; redirect_target = t;
    #3;
    if (m_boot)                    exp_pcd = RESET_ADDR;
    else if (rv)                   exp_pcd = {t[31:2], 2'b00};
    else if (m_fetch && a)         exp_pcd = m_pc + 32'd4;
    else                           exp_pcd = m_pc;
    exp_req   = m_fetch;
    exp_valid = m_held & ~rv;
  endtask

  // Clock edge, then update the model from the inputs that were applied
  task automatic advance();
    @(posedge clk); #1;
    if (m_boot) begin
      m_boot = 1'b0; m_fetch = 1'b1;
    end else if (redirect_valid) begin
      m_fetch = 1'b1; m_held = 1'b0;
    end else if (m_fetch && imem_ack) begin
      m_fetch = 1'b0; m_held = 1'b1; m_instr = imem_rdata; m_instr_pc = m_pc;
    end else if (m_held && instr_ready) begin
      m_held = 1'b0; m_fetch = 1'b1;
    end
    m_pc = exp_pcd;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_fetch = 1'b0; m_held = 1'b0; m_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    checks++; if (pc_d !== RESET_ADDR) begin errors++; $display("FAIL rst_pc_d got=%h exp=%h", pc_d, RESET_ADDR); end
`ifdef PC_TRAP_EN
    checks++; if (trap_valid !== 1'b0 || trap_epc !== 32'h0) begin errors++; $display("FAIL rst_trap got=%b/%h exp=0/0", trap_valid, trap_epc); end
`endif
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (pc_d !== 32'h0040_0000) begin errors++; $display("FAIL boot_pc_d got=%h exp=00400000", pc_d); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL first_addr got=%h exp=00400000", imem_addr); end
    advance();
  endtask

  task automatic test_fetch_hold_redirect();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
      checks++; if (pc_d !== 32'h0040_0000 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_ack got=%h/%b exp=00400000/1", pc_d, imem_req); end
      advance();
    end
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0, '0);
    checks++; if (pc_d !== 32'h0040_0004) begin errors++; $display("FAIL ack_pc_d got=%h exp=00400004", pc_d); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h1111_1111, 1'b0, 1'b0, '0);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", instr_valid); end
      checks++; if (instr !== 32'h2008_0005 || instr_pc !== 32'h0040_0000) begin errors++; $display("FAIL hold_word got=%h@%h exp=20080005@00400000", instr, instr_pc); end
      checks++; if (pc_d !== 32'h0040_0004 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_pc got=%h/%b exp=00400004/0", pc_d, imem_req); end
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b1, 32'h0040_0100);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", instr_valid); end
    checks++; if (pc_d !== 32'h0040_0100) begin errors++; $display("FAIL redir_pc_d got=%h exp=00400100", pc_d); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (imem_addr !== 32'h0040_0100 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_fetch got=%h/%b exp=00400100/1", imem_addr, imem_req); end
    advance();
  endtask

  task automatic test_wrap();
    drive(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    advance();
    drive(1'b1, 32'h0123_4567, 1'b0, 1'b0, '0);
    checks++; if (pc_d !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc_d got=%h exp=00000000", pc_d); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h0123_4567) begin errors++; $display("FAIL wrap_word got=%h@%h exp=01234567@fffffffc", instr, instr_pc); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
    advance();
  endtask

  task automatic test_misaligned();
    drive(1'b0, '0, 1'b0, 1'b1, 32'h0040_0102);
`ifdef PC_TRAP_EN
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_target = '0;
    #3;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL trap_pulse got=%b exp=1", trap_valid); end
    checks++; if (trap_epc !== 32'h0040_0102) begin errors++; $display("FAIL trap_epc got=%h exp=00400102", trap_epc); end
    checks++; if (pc_d !== TRAP_ADDR) begin errors++; $display("FAIL trap_pc_d got=%h exp=%h", pc_d, TRAP_ADDR); end
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== TRAP_ADDR) begin errors++; $display("FAIL trap_fetch got=%b/%h exp=1/%h", imem_req, imem_addr, TRAP_ADDR); end
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL trap_end got=%b exp=0", trap_valid); end
    m_boot = 1'b0; m_fetch = 1'b1; m_held = 1'b0; m_pc = TRAP_ADDR;
`else
    checks++; if (pc_d !== 32'h0040_0100) begin errors++; $display("FAIL misalign_pc_d got=%h exp=00400100", pc_d); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (imem_addr !== 32'h0040_0100 || imem_req !== 1'b1) begin errors++; $display("FAIL misalign_fetch got=%h/%b exp=00400100/1", imem_addr, imem_req); end
    advance();
`endif
  endtask

  task automatic test_back_to_back();
    int xfers = 0;
    for (int i = 0; i < 20; i++) begin
      drive(m_fetch, $urandom, 1'b1, 1'b0, '0);
      if (instr_valid === 1'b1 && instr_ready) xfers++;
      checks++; if (pc_d !== exp_pcd || instr_valid !== exp_valid) begin errors++; $display("FAIL b2b cyc=%0d got=%h/%b exp=%h/%b", i, pc_d, instr_valid, exp_pcd, exp_valid); end
      advance();
    end
    checks++; if (xfers != 10) begin errors++; $display("FAIL b2b_rate got=%0d exp=10", xfers); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    #1 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_d !== RESET_ADDR) begin errors++; $display("FAIL async_fetch got=%b/%h exp=0/%h", imem_req, pc_d, RESET_ADDR); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0); advance();
    drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, '0); advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_ADDR) begin errors++; $display("FAIL async_pre got=%b@%h exp=1@%h", instr_valid, instr_pc, RESET_ADDR); end
    #1 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_hold got=%b exp=0", instr_valid); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic        a, r, rv;
    logic [31:0] t;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        model_reset();
      end
      a  = m_fetch && ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 1) == 1);
      rv = m_boot ? 1'b1 : ($urandom_range(0, 5) == 0);
      t  = $urandom;
`ifdef PC_TRAP_EN
      t[1:0] = 2'b00;
`endif
      drive(a, $urandom, r, rv, t);
      checks++; if (pc_d !== exp_pcd) begin errors++; $display("FAIL rand_pc_d cyc=%0d got=%h exp=%h", i, pc_d, exp_pcd); end
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", i, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      end
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, instr_valid, exp_valid); end
      if (m_held) begin
        checks++; if (instr !== m_instr || instr_pc !== m_instr_pc) begin errors++; $display("FAIL rand_word cyc=%0d got=%h@%h exp=%h@%h", i, instr, instr_pc, m_instr, m_instr_pc); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_hold_redirect();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
